// File: rtl/mig_app_master.sv
// mig_app_master: one-at-a-time request/response port to DDR3 app interface,
// single 128-bit beat per transaction with read timeout and stray-data flag.
module mig_app_master #(
    parameter int ADDR_W      = 28,
    parameter int WORD_AW     = 25,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [WORD_AW-1:0]  req_addr,
    input  logic [127:0]        req_wdata,
    input  logic [15:0]         req_be,
    output logic                rsp_valid,
    output logic [127:0]        rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                stray_err,
    input  logic                init_calib_complete,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [127:0]        app_wdf_data,
    output logic                app_wdf_end,
    output logic [15:0]         app_wdf_mask,
    output logic                app_wdf_wren,
    input  logic                app_wdf_rdy,
    input  logic [127:0]        app_rd_data,
    input  logic                app_rd_data_valid,
    input  logic                app_rd_data_end,
    output logic                app_sr_req,
    output logic                app_ref_req,
    output logic                app_zq_req
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_WAIT} state_t;

    state_t        state;
    logic          cmd_done;
    logic          data_done;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          unused_end;

    assign req_ready   = (state == IDLE) && init_calib_complete;
    assign busy        = state != IDLE;
    assign app_sr_req  = 1'b0;
    assign app_ref_req = 1'b0;
    assign app_zq_req  = 1'b0;
    assign unused_end  = app_rd_data_end;
    // saturating increment: the counter never wraps back to zero
    assign cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state        <= IDLE;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            stray_err    <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= 3'b000;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_end  <= 1'b0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (app_rd_data_valid && state != RD_WAIT)
                stray_err <= 1'b1;
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    app_addr  <= ADDR_W'({req_addr, 3'b000});
                    app_cmd   <= {2'b00, ~req_we};
                    app_en    <= 1'b1;
                    cmd_done  <= 1'b0;
                    data_done <= 1'b0;
                    if (req_we) begin
                        app_wdf_data <= req_wdata;
                        app_wdf_mask <= ~req_be;
                        app_wdf_wren <= 1'b1;
                        app_wdf_end  <= 1'b1;
                    end
                    state <= req_we ? WRITE : RD_CMD;
                end
                WRITE: begin
                    if (app_en && app_rdy) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        data_done    <= 1'b1;
                    end
                    if (cmd_done && data_done) begin
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RD_CMD: if (app_rdy) begin
                    app_en <= 1'b0;
                    cnt    <= '0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt <= cnt_inc;
                    if (app_rd_data_valid) begin
                        rsp_rdata <= app_rd_data;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt_inc == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mig_app_master.sv
// tb_mig_app_master: directed checks of gating, write/read handshakes,
// timeout, stray-data flag and mid-transaction reset.
module tb_mig_app_master;
    logic         clk = 0;
    logic         rst;
    logic         req_valid, req_ready, req_we;
    logic [24:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_be;
    logic         rsp_valid, rsp_err, busy, stray_err;
    logic [127:0] rsp_rdata;
    logic         calib;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end, app_wdf_wren, app_wdf_rdy;
    logic [15:0]  app_wdf_mask;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         sr_req, ref_req, zq_req;
    int           checks = 0;
    int           errors = 0;
    logic         seen;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] RD = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] RD2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    always #5 clk = ~clk;

    mig_app_master #(.TIMEOUT_CYC(16)) dut (
        .ui_clk(clk), .ui_clk_sync_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .stray_err(stray_err), .init_calib_complete(calib),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(1'b0),
        .app_sr_req(sr_req), .app_ref_req(ref_req), .app_zq_req(zq_req)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench in the first cycle after acceptance
    task automatic issue(input logic we, input logic [24:0] a, input logic [127:0] d, input logic [15:0] be);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        tick();
        req_valid = 0;
    endtask

    initial begin
        rst = 1; calib = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        req_be = 0; app_rdy = 0; app_wdf_rdy = 0; app_rd_data = 0; app_rd_data_valid = 0;
        tick(); tick();
        rst = 0;
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_stray", stray_err, 0);
        check("rst_side_reqs", {sr_req, ref_req, zq_req}, 0);

        // calibration gating
        app_rdy = 1; app_wdf_rdy = 1;
        req_valid = 1; req_we = 1; req_addr = 25'h0000123; req_wdata = A5; req_be = 16'h00FF;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= req_ready | app_en;
        end
        check("gate_blocked", seen, 0);
        calib = 1;
        #1;
        check("gate_ready", req_ready, 1);
        tick();
        req_valid = 0;
        check("wr_en", app_en, 1);
        check("wr_cmd", app_cmd, 3'b000);
        check("wr_addr", app_addr, 28'h0000918);
        check("wr_wren_end", {app_wdf_wren, app_wdf_end}, 2'b11);
        check("wr_mask", app_wdf_mask, 16'hFF00);
        check("wr_data", app_wdf_data, A5);
        check("wr_ready_low", req_ready, 0);
        tick();
        check("wr_en_drop", {app_en, app_wdf_wren, rsp_valid}, 0);
        tick();
        check("wr_rsp", {rsp_valid, rsp_err, busy}, 3'b100);
        tick();
        check("wr_rsp_pulse", rsp_valid, 0);

        // write with cmd accepted in cycle 5 and data in cycle 8
        app_rdy = 0; app_wdf_rdy = 0;
        issue(1, 25'h1, RD2, 16'hFFFF);
        check("wr2_mask", app_wdf_mask, 16'h0000);
        for (int n = 1; n <= 12; n++) begin
            app_rdy = (n >= 5); app_wdf_rdy = (n >= 8);
            check($sformatf("wr2_en_c%0d", n), app_en, n <= 5);
            check($sformatf("wr2_wren_c%0d", n), app_wdf_wren, n <= 8);
            check($sformatf("wr2_rsp_c%0d", n), rsp_valid, n == 10);
            tick();
        end

        // read: cmd accepted cycle 4, data cycle 14, rsp cycle 15
        app_rdy = 0;
        issue(0, 25'h2A, 0, 0);
        check("rd_cmd", app_cmd, 3'b001);
        check("rd_addr", app_addr, 28'h0000150);
        app_rd_data = RD;
        for (int n = 1; n <= 16; n++) begin
            app_rdy = (n >= 4); app_rd_data_valid = (n == 14);
            check($sformatf("rd_en_c%0d", n), app_en, n <= 4);
            check($sformatf("rd_rsp_c%0d", n), rsp_valid, n == 15);
            check($sformatf("rd_busy_c%0d", n), busy, n < 15);
            if (n == 15) begin
                check("rd_rdata", rsp_rdata, RD);
                check("rd_err", rsp_err, 0);
            end
            tick();
        end
        app_rd_data_valid = 0;
        check("rd_no_stray", stray_err, 0);

        // timeout: cmd accepted cycle 1, error response 16 cycles later
        app_rdy = 1; app_rd_data = RD2;
        issue(0, 25'h3, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            check($sformatf("to_rsp_c%0d", n), {rsp_valid, rsp_err}, (n == 17) ? 2'b11 : 2'b00);
            if (n == 17) check("to_rdata_held", rsp_rdata, RD);
            tick();
        end
        check("to_idle", busy, 0);
        app_rd_data_valid = 1;
        tick();
        app_rd_data_valid = 0;
        check("stray_set", stray_err, 1);
        check("stray_rdata_unchanged", rsp_rdata, RD);
        tick(); tick();
        check("stray_sticky", stray_err, 1);

        // reset in the middle of a stalled write
        app_rdy = 0; app_wdf_rdy = 1;
        issue(1, 25'h7, A5, 16'hFFFF);
        check("rw_en_before", app_en, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rw_after_rst", {app_en, app_wdf_wren, busy, stray_err}, 0);
        app_rdy = 1; app_rd_data = RD2;
        issue(0, 25'h10, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            app_rd_data_valid = (n == 4);
            check($sformatf("rr_rsp_c%0d", n), rsp_valid, n == 5);
            if (n == 5) check("rr_rdata", rsp_rdata, RD2);
            tick();
        end
        app_rd_data_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
